// File: rtl/pipe_reg_chain.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pipe_reg_chain
// Purpose  : Parametrised inter-stage pipeline register. It is a chain of
//            DEPTH registered stages, each WIDTH bits wide, with a valid bit
//            per stage. It supports valid/ready flow control, bubble
//            collapsing, a global advance enable and a synchronous flush.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH      data bits per stage (>=1)
//   DEPTH      number of register stages (>=1, keep <=8 for timing)
// Ports
//   clk        rising-edge clock
//   reset      asynchronous assert, active-low reset
//   enable     global advance enable; 0 freezes all state
//   flush      synchronous clear of every valid bit
//   in_valid   upstream offers in_data
//   in_ready   chain accepts in_data this cycle
//   in_data    upstream payload
//   out_valid  out_data is valid
//   out_ready  downstream accepts out_data
//   out_data   payload of the last stage
//   occupancy  number of valid stages (only with PIPE_REG_CHAIN_OCC_EN)
// Build option
//   PIPE_REG_CHAIN_OCC_EN  when defined, adds the occupancy port and counter
// ============================================================================
module pipe_reg_chain #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_REG_CHAIN_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_v;
  logic [DEPTH-1:0] w_rdy;

  // The ready chain runs from the output back to the input. A running scalar
  // is used so that no bit of w_rdy is computed from another bit of itself.
  always_comb begin : p_ready
    logic l_chain;
    w_rdy   = '0;
    l_chain = !r_v[DEPTH-1] || out_ready;
    w_rdy[DEPTH-1] = l_chain;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      // An empty stage can always take data. This is what collapses bubbles.
      l_chain  = !r_v[i] || l_chain;
      w_rdy[i] = l_chain;
    end
  end

  assign in_ready  = enable && !flush && w_rdy[0];
  assign out_valid = enable && !flush && r_v[DEPTH-1];
  assign out_data  = r_data[DEPTH-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
    end else if (flush) begin
      // Flush wins over enable. Only the valid bits clear; the payloads stay.
      r_v <= '0;
    end else if (enable) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        if (w_rdy[i]) begin
          r_v[i] <= r_v[i-1];
          // The payload of an invalid stage is don't-care. It is left alone
          // so the data flops do not toggle needlessly.
          if (r_v[i-1]) begin
            r_data[i] <= r_data[i-1];
          end
        end
      end
      if (w_rdy[0]) begin
        r_v[0] <= in_valid;
        if (in_valid) begin
          r_data[0] <= in_data;
        end
      end
    end
  end

`ifdef PIPE_REG_CHAIN_OCC_EN
  localparam int c_OCC_W = $clog2(DEPTH + 1);

  logic [c_OCC_W-1:0] r_occ;
  logic               w_in_xfer;
  logic               w_out_xfer;

  // Both transfers already imply enable=1 and flush=0.
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;

  // The counter tracks popcount(r_v). Shifting stages inside the chain never
  // changes the count. Only the two end transfers change it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else if (w_in_xfer && !w_out_xfer) begin
      r_occ <= r_occ + c_OCC_W'(1);
    end else if (!w_in_xfer && w_out_xfer) begin
      r_occ <= r_occ - c_OCC_W'(1);
    end
  end

  assign occupancy = r_occ;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_reg_chain.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pipe_reg_chain
// Purpose  : Directed self-checking bench for pipe_reg_chain with WIDTH=8 and
//            DEPTH=3. It covers latency, back-pressure, bubble collapse,
//            stall, flush and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_reg_chain;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;

  logic             clk       = 1'b0;
  logic             reset     = 1'b0;
  logic             enable    = 1'b1;
  logic             flush     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] in_data   = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
`ifdef PIPE_REG_CHAIN_OCC_EN
  logic [1:0]       occupancy;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_reg_chain #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_REG_CHAIN_OCC_EN
    ,
    .occupancy (occupancy)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_occ(input string tag, input logic [31:0] exp);
`ifdef PIPE_REG_CHAIN_OCC_EN
    chk(tag, 32'(occupancy), exp);
`else
    if (tag.len() < 0) chk(tag, exp, exp);
`endif
  endtask

  // Moves to 1 ns after the next rising edge, where new inputs are driven.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Lets the combinational outputs settle after the inputs change.
  task automatic settle;
    #1;
  endtask

`ifdef PIPE_REG_CHAIN_OCC_EN
  // The occupancy counter must always match the popcount of the valid bits.
  always @(negedge clk) begin
    checks++;
    assert (32'(occupancy) === 32'($countones(dut.r_v))) else begin
      errors++;
      $error("FAIL occ_popcount: observed 0x%0h expected 0x%0h",
             occupancy, $countones(dut.r_v));
    end
  end
`endif

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset state
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk_occ("rst_occ", 32'h0);
    tick;
    tick;
    reset = 1'b1;

    // ---------------- latency and throughput
    in_valid = 1'b1; in_data = 8'h11; settle;
    chk("lat_in_ready", 32'(in_ready), 32'h1);
    tick;
    in_data = 8'h22; settle;
    chk("lat_e0_ov", 32'(out_valid), 32'h0);
    tick;
    in_data = 8'h33; settle;
    chk("lat_e1_ov", 32'(out_valid), 32'h0);
    tick;
    in_valid = 1'b0; settle;
    chk("lat_e2_ov", 32'(out_valid), 32'h1);
    chk("lat_d11", 32'(out_data), 32'h11);
    chk_occ("lat_occ3", 32'h3);
    tick; settle;
    chk("lat_ov22", 32'(out_valid), 32'h1);
    chk("lat_d22", 32'(out_data), 32'h22);
    chk_occ("lat_occ2", 32'h2);
    tick; settle;
    chk("lat_d33", 32'(out_data), 32'h33);
    chk_occ("lat_occ1", 32'h1);
    tick; settle;
    chk("lat_empty", 32'(out_valid), 32'h0);
    chk_occ("lat_occ0", 32'h0);

    // ---------------- back-pressure
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h01; settle;
    chk("bp_rdy1", 32'(in_ready), 32'h1);
    tick; in_data = 8'h02;
    tick; in_data = 8'h03;
    tick; in_data = 8'h04; settle;
    chk("bp_full_rdy", 32'(in_ready), 32'h0);
    chk("bp_full_d", 32'(out_data), 32'h01);
    chk_occ("bp_occ3", 32'h3);
    tick; settle;
    chk("bp_hold_rdy", 32'(in_ready), 32'h0);
    chk("bp_hold_d", 32'(out_data), 32'h01);
    out_ready = 1'b1; settle;
    chk("bp_release_rdy", 32'(in_ready), 32'h1);
    tick;
    in_data = 8'h05; settle;
    chk("bp_d02", 32'(out_data), 32'h02);
    chk_occ("bp_occ_swap", 32'h3);
    tick;
    in_valid = 1'b0; settle;
    chk("bp_d03", 32'(out_data), 32'h03);
    tick; settle;
    chk("bp_d04", 32'(out_data), 32'h04);
    tick; settle;
    chk("bp_d05", 32'(out_data), 32'h05);
    chk("bp_ov05", 32'(out_valid), 32'h1);
    chk_occ("bp_occ1", 32'h1);
    tick; settle;
    chk("bp_empty", 32'(out_valid), 32'h0);

    // ---------------- bubble collapse
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hA0;
    tick;
    in_valid = 1'b0;
    tick;
    in_valid = 1'b1; in_data = 8'hA1; settle;
    chk("bub_rdy_a1", 32'(in_ready), 32'h1);
    tick;
    in_valid = 1'b0; settle;
    chk("bub_head", 32'(out_data), 32'hA0);
    chk("bub_rdy_gap", 32'(in_ready), 32'h1);
    chk_occ("bub_occ2", 32'h2);
    tick;
    in_valid = 1'b1; in_data = 8'hA2; settle;
    chk("bub_rdy_third", 32'(in_ready), 32'h1);
    tick;
    in_valid = 1'b0; settle;
    chk("bub_rdy_full", 32'(in_ready), 32'h0);
    chk_occ("bub_occ3", 32'h3);
    out_ready = 1'b1; settle;
    chk("bub_dA0", 32'(out_data), 32'hA0);
    tick; settle;
    chk("bub_dA1", 32'(out_data), 32'hA1);
    tick; settle;
    chk("bub_dA2", 32'(out_data), 32'hA2);
    tick; settle;
    chk("bub_empty", 32'(out_valid), 32'h0);

    // ---------------- stall with enable low
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h5A;
    tick; in_data = 8'h5B;
    tick; in_valid = 1'b0;
    tick;
    enable = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    for (int k = 0; k < 4; k++) begin
      settle;
      chk("stall_ov", 32'(out_valid), 32'h0);
      chk("stall_rdy", 32'(in_ready), 32'h0);
      chk_occ("stall_occ", 32'h2);
      tick;
    end
    enable = 1'b1; in_valid = 1'b0; settle;
    chk("stall_ov_5A", 32'(out_valid), 32'h1);
    chk("stall_d5A", 32'(out_data), 32'h5A);
    tick; settle;
    chk("stall_d5B", 32'(out_data), 32'h5B);
    tick; settle;
    chk("stall_empty", 32'(out_valid), 32'h0);

    // ---------------- flush
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hC1;
    tick; in_data = 8'hC2;
    tick; in_data = 8'hC3;
    tick;
    flush = 1'b1; out_ready = 1'b1; in_data = 8'hC4; settle;
    chk("fl_rdy", 32'(in_ready), 32'h0);
    chk("fl_ov", 32'(out_valid), 32'h0);
    tick;
    flush = 1'b0; in_valid = 1'b0; settle;
    chk("fl_after_ov", 32'(out_valid), 32'h0);
    chk("fl_after_rdy", 32'(in_ready), 32'h1);
    chk_occ("fl_occ0", 32'h0);
    tick; settle;
    chk("fl_no_c4", 32'(out_valid), 32'h0);

    // ---------------- asynchronous reset while full
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hD1;
    tick; in_data = 8'hD2;
    tick; in_data = 8'hD3;
    tick;
    in_valid = 1'b0; settle;
    chk("ar_full_ov", 32'(out_valid), 32'h1);
    chk_occ("ar_full_occ", 32'h3);
    reset = 1'b0; #1;
    chk("ar_ov", 32'(out_valid), 32'h0);
    chk("ar_d", 32'(out_data), 32'h0);
    chk("ar_rdy", 32'(in_ready), 32'h1);
    chk_occ("ar_occ", 32'h0);
    tick;
    reset = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hE5; settle;
    chk("ar_post_rdy", 32'(in_ready), 32'h1);
    tick;
    in_valid = 1'b0; settle;
    chk("ar_lat_e0", 32'(out_valid), 32'h0);
    tick; settle;
    chk("ar_lat_e1", 32'(out_valid), 32'h0);
    tick; settle;
    chk("ar_lat_e2", 32'(out_valid), 32'h1);
    chk("ar_dE5", 32'(out_data), 32'hE5);
    tick; settle;
    chk("ar_empty", 32'(out_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
